// File: rtl/ps2_key_event_tracker.sv
// PS/2 scan-code set 2 byte decoder.
// Parses make, break and E0-extended sequences and filters typematic repeats.
// Tracks modifier state, caps lock, the held key and a press counter.
// Decoded events are queued in a first-word-fall-through FIFO.
module ps2_key_event_tracker #(
  parameter int FIFO_DEPTH    = 8,
  parameter int CNT_W         = 8,
  parameter int REPEAT_FILTER = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic [9:0]                    evt_data,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          proto_err,
  output logic [CNT_W-1:0]              press_cnt,
  output logic                          held_valid,
  output logic [8:0]                    held_code,
  output logic                          shift,
  output logic                          ctrl,
  output logic                          caps_lock
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [8:0] K_LSHIFT = 9'h012;
  localparam logic [8:0] K_RSHIFT = 9'h059;
  localparam logic [8:0] K_LCTRL  = 9'h014;
  localparam logic [8:0] K_RCTRL  = 9'h114;
  localparam logic [8:0] K_CAPS   = 9'h058;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t state_q, state_d;

  logic       evt_fire, evt_brk, evt_ext, err_fire;
  logic [7:0] evt_code;
  logic [8:0] key;
  logic       is_make, is_brk, repeat_hit, accept_make, push, pop, full, push_ok;

  logic [9:0]       mem_q [FIFO_DEPTH];
  logic [9:0]       mem_d [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d, proto_err_q, proto_err_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic             held_valid_q, held_valid_d;
  logic [8:0]       held_code_q, held_code_d;
  logic             lshift_q, lshift_d, rshift_q, rshift_d;
  logic             lctrl_q, lctrl_d, rctrl_q, rctrl_d;
  logic             caps_q, caps_d;

  // Parser state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Parser next-state: prefixes move forward, anything else returns to IDLE
  always_comb begin
    state_d = state_q;
    if (in_valid) begin
      case (state_q)
        S_IDLE: begin
          if (in_data == 8'hE0)      state_d = S_EXT;
          else if (in_data == 8'hF0) state_d = S_BRK;
          else                       state_d = S_IDLE;
        end
        S_EXT: begin
          if (in_data == 8'hF0) state_d = S_EXT_BRK;
          else                  state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Parser outputs: decoded event strobe or protocol error for the current byte
  always_comb begin
    evt_fire = 1'b0;
    evt_brk  = 1'b0;
    evt_ext  = 1'b0;
    err_fire = 1'b0;
    evt_code = in_data;
    if (in_valid) begin
      case (state_q)
        S_IDLE: begin
          if (in_data == 8'h00 || in_data == 8'hFF || in_data == 8'hE1) err_fire = 1'b1;
          else if (in_data != 8'hE0 && in_data != 8'hF0)                evt_fire = 1'b1;
        end
        S_EXT: begin
          if (in_data == 8'hE0 || in_data == 8'h00 || in_data == 8'hFF) err_fire = 1'b1;
          else if (in_data != 8'hF0) begin
            evt_fire = 1'b1;
            evt_ext  = 1'b1;
          end
        end
        default: begin
          if (in_data == 8'hE0 || in_data == 8'hF0 || in_data == 8'h00 || in_data == 8'hFF) begin
            err_fire = 1'b1;
          end else begin
            evt_fire = 1'b1;
            evt_brk  = 1'b1;
            evt_ext  = (state_q == S_EXT_BRK);
          end
        end
      endcase
    end
  end

  assign key         = {evt_ext, evt_code};
  assign is_make     = evt_fire && !evt_brk;
  assign is_brk      = evt_fire && evt_brk;
  assign repeat_hit  = is_make && (REPEAT_FILTER != 0) && held_valid_q && (held_code_q == key);
  assign accept_make = is_make && !repeat_hit;
  assign push        = accept_make || is_brk;
  assign pop         = (count_q != '0) && evt_ready;
  assign full        = (count_q == FULL_CNT);
  assign push_ok     = push && (!full || pop);

  // Key tracking and FIFO bookkeeping for the event decoded this cycle
  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q + CW'(push_ok) - CW'(pop);
    overflow_d   = overflow_q || (push && full && !pop);
    proto_err_d  = proto_err_q || err_fire;
    press_cnt_d  = press_cnt_q;
    held_valid_d = held_valid_q;
    held_code_d  = held_code_q;
    lshift_d     = lshift_q;
    rshift_d     = rshift_q;
    lctrl_d      = lctrl_q;
    rctrl_d      = rctrl_q;
    caps_d       = caps_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = {evt_brk, evt_ext, evt_code};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    if (accept_make) begin
      press_cnt_d  = press_cnt_q + CNT_W'(1);
      held_code_d  = key;
      held_valid_d = 1'b1;
      if (key == K_CAPS) caps_d = !caps_q;
    end
    if (is_brk && key == held_code_q) held_valid_d = 1'b0;

    if (evt_fire) begin
      if (key == K_LSHIFT) lshift_d = is_make;
      if (key == K_RSHIFT) rshift_d = is_make;
      if (key == K_LCTRL)  lctrl_d  = is_make;
      if (key == K_RCTRL)  rctrl_d  = is_make;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      proto_err_q  <= 1'b0;
      press_cnt_q  <= '0;
      held_valid_q <= 1'b0;
      held_code_q  <= '0;
      lshift_q     <= 1'b0;
      rshift_q     <= 1'b0;
      lctrl_q      <= 1'b0;
      rctrl_q      <= 1'b0;
      caps_q       <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      proto_err_q  <= proto_err_d;
      press_cnt_q  <= press_cnt_d;
      held_valid_q <= held_valid_d;
      held_code_q  <= held_code_d;
      lshift_q     <= lshift_d;
      rshift_q     <= rshift_d;
      lctrl_q      <= lctrl_d;
      rctrl_q      <= rctrl_d;
      caps_q       <= caps_d;
    end
  end

  assign evt_data   = mem_q[rd_ptr_q];
  assign evt_valid  = (count_q != '0);
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign proto_err  = proto_err_q;
  assign press_cnt  = press_cnt_q;
  assign held_valid = held_valid_q;
  assign held_code  = held_code_q;
  assign shift      = lshift_q | rshift_q;
  assign ctrl       = lctrl_q | rctrl_q;
  assign caps_lock  = caps_q;

endmodule

// File: tb/tb_ps2_key_event_tracker.sv
// Directed testbench for ps2_key_event_tracker.
// Three instances share one input stream: default, repeat filter off, depth 4.
module tb_ps2_key_event_tracker;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       evt_ready;

  logic [9:0] d8_evt_data, nf_evt_data, d4_evt_data;
  logic       d8_evt_valid, nf_evt_valid, d4_evt_valid;
  logic [3:0] d8_fifo_count, nf_fifo_count;
  logic [2:0] d4_fifo_count;
  logic       d8_overflow, nf_overflow, d4_overflow;
  logic       d8_proto_err, nf_proto_err, d4_proto_err;
  logic [7:0] d8_press_cnt, nf_press_cnt, d4_press_cnt;
  logic       d8_held_valid, nf_held_valid, d4_held_valid;
  logic [8:0] d8_held_code, nf_held_code, d4_held_code;
  logic       d8_shift, nf_shift, d4_shift;
  logic       d8_ctrl, nf_ctrl, d4_ctrl;
  logic       d8_caps, nf_caps, d4_caps;

  int checks = 0;
  int passed = 0;

  ps2_key_event_tracker #(.FIFO_DEPTH(8), .CNT_W(8), .REPEAT_FILTER(1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .evt_data(d8_evt_data), .evt_valid(d8_evt_valid), .evt_ready(evt_ready),
    .fifo_count(d8_fifo_count), .overflow(d8_overflow), .proto_err(d8_proto_err),
    .press_cnt(d8_press_cnt), .held_valid(d8_held_valid), .held_code(d8_held_code),
    .shift(d8_shift), .ctrl(d8_ctrl), .caps_lock(d8_caps)
  );

  ps2_key_event_tracker #(.FIFO_DEPTH(8), .CNT_W(8), .REPEAT_FILTER(0)) dut_nf (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .evt_data(nf_evt_data), .evt_valid(nf_evt_valid), .evt_ready(evt_ready),
    .fifo_count(nf_fifo_count), .overflow(nf_overflow), .proto_err(nf_proto_err),
    .press_cnt(nf_press_cnt), .held_valid(nf_held_valid), .held_code(nf_held_code),
    .shift(nf_shift), .ctrl(nf_ctrl), .caps_lock(nf_caps)
  );

  ps2_key_event_tracker #(.FIFO_DEPTH(4), .CNT_W(8), .REPEAT_FILTER(1)) dut_d4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .evt_data(d4_evt_data), .evt_valid(d4_evt_valid), .evt_ready(evt_ready),
    .fifo_count(d4_fifo_count), .overflow(d4_overflow), .proto_err(d4_proto_err),
    .press_cnt(d4_press_cnt), .held_valid(d4_held_valid), .held_code(d4_held_code),
    .shift(d4_shift), .ctrl(d4_ctrl), .caps_lock(d4_caps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land 1ns past the edge so outputs are settled
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte for exactly one clock
  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Hold reset low for one edge with idle inputs
  task automatic do_reset();
    rst       = 1'b0;
    in_valid  = 1'b0;
    evt_ready = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // Every output must read zero right after reset
  task automatic test_reset();
    do_reset();
    checks++; if ({d8_evt_valid, d8_fifo_count, d8_evt_data} !== 15'd0) $display("[TB] FAIL rst_fifo: got %h expected 0", {d8_evt_valid, d8_fifo_count, d8_evt_data}); else passed++;
    checks++; if ({d8_overflow, d8_proto_err, d8_press_cnt} !== 10'd0) $display("[TB] FAIL rst_status: got %h expected 0", {d8_overflow, d8_proto_err, d8_press_cnt}); else passed++;
    checks++; if ({d8_held_valid, d8_held_code, d8_shift, d8_ctrl, d8_caps} !== 13'd0) $display("[TB] FAIL rst_keys: got %h expected 0", {d8_held_valid, d8_held_code, d8_shift, d8_ctrl, d8_caps}); else passed++;
  endtask

  // Plain make then break, consumer stalled so both events queue up
  task automatic test_make_break();
    logic [9:0] exp_q [2];
    exp_q[0] = 10'h01C;
    exp_q[1] = 10'h21C;
    do_reset();
    send_byte(8'h1C);
    checks++; if (d8_evt_valid !== 1'b1 || d8_evt_data !== 10'h01C) $display("[TB] FAIL mb_latency: got v=%b d=%h expected v=1 d=01c", d8_evt_valid, d8_evt_data); else passed++;
    checks++; if (d8_held_valid !== 1'b1 || d8_held_code !== 9'h01C) $display("[TB] FAIL mb_held_make: got v=%b c=%h expected v=1 c=01c", d8_held_valid, d8_held_code); else passed++;
    send_byte(8'hF0);
    send_byte(8'h1C);
    checks++; if (d8_held_valid !== 1'b0) $display("[TB] FAIL mb_held_break: got %b expected 0", d8_held_valid); else passed++;
    checks++; if (d8_press_cnt !== 8'd1 || d8_fifo_count !== 4'd2) $display("[TB] FAIL mb_counts: got cnt=%0d occ=%0d expected cnt=1 occ=2", d8_press_cnt, d8_fifo_count); else passed++;
    for (int i = 0; i < 2; i++) begin
      checks++; if (d8_evt_valid !== 1'b1 || d8_evt_data !== exp_q[i]) $display("[TB] FAIL mb_drain%0d: got v=%b d=%h expected v=1 d=%h", i, d8_evt_valid, d8_evt_data, exp_q[i]); else passed++;
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
    end
    checks++; if (d8_evt_valid !== 1'b0) $display("[TB] FAIL mb_empty: got %b expected 0", d8_evt_valid); else passed++;
  endtask

  // Extended key with typematic repeats, filtered and unfiltered
  task automatic test_repeat_filter();
    logic [9:0] exp_nf [4];
    logic [9:0] exp_f  [2];
    exp_nf[0] = 10'h175; exp_nf[1] = 10'h175; exp_nf[2] = 10'h175; exp_nf[3] = 10'h375;
    exp_f[0]  = 10'h175; exp_f[1]  = 10'h375;
    do_reset();
    send_byte(8'hE0); send_byte(8'h75);
    checks++; if (d8_held_valid !== 1'b1 || d8_held_code !== 9'h175) $display("[TB] FAIL rep_held: got v=%b c=%h expected v=1 c=175", d8_held_valid, d8_held_code); else passed++;
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    checks++; if (d8_press_cnt !== 8'd1 || d8_fifo_count !== 4'd2) $display("[TB] FAIL rep_filt_counts: got cnt=%0d occ=%0d expected cnt=1 occ=2", d8_press_cnt, d8_fifo_count); else passed++;
    checks++; if (nf_press_cnt !== 8'd3 || nf_fifo_count !== 4'd4) $display("[TB] FAIL rep_nofilt_counts: got cnt=%0d occ=%0d expected cnt=3 occ=4", nf_press_cnt, nf_fifo_count); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (nf_evt_data !== exp_nf[i]) $display("[TB] FAIL rep_nofilt_ev%0d: got %h expected %h", i, nf_evt_data, exp_nf[i]); else passed++;
      if (i < 2) begin
        checks++; if (d8_evt_data !== exp_f[i]) $display("[TB] FAIL rep_filt_ev%0d: got %h expected %h", i, d8_evt_data, exp_f[i]); else passed++;
      end
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
    end
  endtask

  // Shift, ctrl and caps lock tracking with the consumer always ready
  task automatic test_modifiers();
    do_reset();
    evt_ready = 1'b1;
    send_byte(8'h12);
    send_byte(8'h59);
    send_byte(8'hF0); send_byte(8'h12);
    checks++; if (d8_shift !== 1'b1) $display("[TB] FAIL mod_shift_held: got %b expected 1", d8_shift); else passed++;
    checks++; if (d8_held_valid !== 1'b1 || d8_held_code !== 9'h059) $display("[TB] FAIL mod_held_nomatch: got v=%b c=%h expected v=1 c=059", d8_held_valid, d8_held_code); else passed++;
    send_byte(8'hF0); send_byte(8'h59);
    checks++; if (d8_shift !== 1'b0) $display("[TB] FAIL mod_shift_rel: got %b expected 0", d8_shift); else passed++;
    send_byte(8'hE0); send_byte(8'h14);
    checks++; if (d8_ctrl !== 1'b1) $display("[TB] FAIL mod_rctrl: got %b expected 1", d8_ctrl); else passed++;
    send_byte(8'h58);
    checks++; if (d8_caps !== 1'b1) $display("[TB] FAIL mod_caps_on: got %b expected 1", d8_caps); else passed++;
    send_byte(8'hF0); send_byte(8'h58);
    checks++; if (d8_caps !== 1'b1) $display("[TB] FAIL mod_caps_brk: got %b expected 1", d8_caps); else passed++;
    send_byte(8'h58);
    checks++; if (d8_caps !== 1'b0) $display("[TB] FAIL mod_caps_off: got %b expected 0", d8_caps); else passed++;
    checks++; if (d8_press_cnt !== 8'd5) $display("[TB] FAIL mod_press_cnt: got %0d expected 5", d8_press_cnt); else passed++;
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h14);
    checks++; if (d8_ctrl !== 1'b0) $display("[TB] FAIL mod_rctrl_rel: got %b expected 0", d8_ctrl); else passed++;
    evt_ready = 1'b0;
  endtask

  // Fill the depth-4 FIFO past capacity, then push and pop together at full
  task automatic test_fifo_full();
    logic [9:0] exp_q [4];
    exp_q[0] = 10'h01D; exp_q[1] = 10'h024; exp_q[2] = 10'h02D; exp_q[3] = 10'h036;
    do_reset();
    send_byte(8'h15); send_byte(8'h1D); send_byte(8'h24);
    send_byte(8'h2D); send_byte(8'h2C); send_byte(8'h35);
    checks++; if (d4_fifo_count !== 3'd4 || d4_overflow !== 1'b1) $display("[TB] FAIL full_d4: got occ=%0d ovf=%b expected occ=4 ovf=1", d4_fifo_count, d4_overflow); else passed++;
    checks++; if (d8_fifo_count !== 4'd6 || d8_overflow !== 1'b0) $display("[TB] FAIL full_d8: got occ=%0d ovf=%b expected occ=6 ovf=0", d8_fifo_count, d8_overflow); else passed++;
    checks++; if (d4_evt_data !== 10'h015) $display("[TB] FAIL full_head: got %h expected 015", d4_evt_data); else passed++;
    evt_ready = 1'b1;
    send_byte(8'h36);
    evt_ready = 1'b0;
    checks++; if (d4_fifo_count !== 3'd4) $display("[TB] FAIL full_pushpop: got %0d expected 4", d4_fifo_count); else passed++;
    checks++; if (d8_fifo_count !== 4'd6) $display("[TB] FAIL pushpop_d8: got %0d expected 6", d8_fifo_count); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (d4_evt_valid !== 1'b1 || d4_evt_data !== exp_q[i]) $display("[TB] FAIL full_drain%0d: got v=%b d=%h expected v=1 d=%h", i, d4_evt_valid, d4_evt_data, exp_q[i]); else passed++;
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
    end
    checks++; if (d4_fifo_count !== 3'd0 || d4_overflow !== 1'b1) $display("[TB] FAIL full_after: got occ=%0d ovf=%b expected occ=0 ovf=1", d4_fifo_count, d4_overflow); else passed++;
  endtask

  // Malformed sequences set the sticky error and the parser recovers
  task automatic test_proto_err();
    do_reset();
    send_byte(8'hE0); send_byte(8'hE0);
    checks++; if (d8_proto_err !== 1'b1 || d8_fifo_count !== 4'd0) $display("[TB] FAIL perr_e0e0: got err=%b occ=%0d expected err=1 occ=0", d8_proto_err, d8_fifo_count); else passed++;
    send_byte(8'h1C);
    checks++; if (d8_evt_data !== 10'h01C || d8_fifo_count !== 4'd1) $display("[TB] FAIL perr_recover: got d=%h occ=%0d expected d=01c occ=1", d8_evt_data, d8_fifo_count); else passed++;
    do_reset();
    send_byte(8'hF0); send_byte(8'hF0);
    checks++; if (d8_proto_err !== 1'b1 || d8_fifo_count !== 4'd0) $display("[TB] FAIL perr_f0f0: got err=%b occ=%0d expected err=1 occ=0", d8_proto_err, d8_fifo_count); else passed++;
    do_reset();
    send_byte(8'hE1);
    checks++; if (d8_proto_err !== 1'b1 || d8_fifo_count !== 4'd0) $display("[TB] FAIL perr_e1: got err=%b occ=%0d expected err=1 occ=0", d8_proto_err, d8_fifo_count); else passed++;
  endtask

  // Reset in the middle of an extended sequence, with a byte arriving at the same edge
  task automatic test_reset_mid();
    do_reset();
    send_byte(8'hE0);
    rst      = 1'b0;
    in_data  = 8'h1C;
    in_valid = 1'b1;
    tick();
    rst      = 1'b1;
    in_valid = 1'b0;
    checks++; if ({d8_evt_valid, d8_fifo_count, d8_press_cnt, d8_held_valid, d8_proto_err} !== 15'd0) $display("[TB] FAIL rmid_cleared: got %h expected 0", {d8_evt_valid, d8_fifo_count, d8_press_cnt, d8_held_valid, d8_proto_err}); else passed++;
    send_byte(8'h1C);
    checks++; if (d8_evt_data !== 10'h01C || d8_press_cnt !== 8'd1) $display("[TB] FAIL rmid_event: got d=%h cnt=%0d expected d=01c cnt=1", d8_evt_data, d8_press_cnt); else passed++;
  endtask

  // Run every scenario in order, then report
  initial begin
    rst       = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    evt_ready = 1'b0;
    tick();
    test_reset();
    test_make_break();
    test_repeat_filter();
    test_modifiers();
    test_fifo_full();
    test_proto_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_tracker.md
Name: ps2_key_event_tracker

Overview:
Byte-level PS/2 scan-code set 2 decoder that sits between the PS/2 serial receiver and display or ASCII logic. It parses make, break and E0-extended sequences and filters typematic auto-repeat. It also tracks modifier state and the currently held key, counts key presses, and queues decoded key events in a parametrised FIFO with a valid/ready output handshake.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of two, >= 2
CNT_W, 8, width of the press counter
REPEAT_FILTER, 1, 1 = suppress repeated make codes of the held key; 0 = pass them through

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-low
in_data  input  8  received scan-code byte
in_valid  input  1  one-cycle strobe; in_data is valid this cycle; always accepted
evt_data  output  10  head event {brk, ext, code[7:0]}
evt_valid  output  1  FIFO non-empty
evt_ready  input  1  consumer pops the head when evt_valid && evt_ready
fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy
overflow  output  1  sticky; an event was dropped because the FIFO was full
proto_err  output  1  sticky; a malformed sequence was seen
press_cnt  output  CNT_W  count of accepted make events
held_valid  output  1  a key is held
held_code  output  9  {ext, code} of the most recent held key
shift  output  1  left shift (12) or right shift (59) held
ctrl  output  1  left ctrl (14) or right ctrl (E0 14) held
caps_lock  output  1  toggle state

Behaviour:
- Reset: rst sampled low at a clk edge clears every register. All outputs are 0, the FIFO is empty, the FSM is in IDLE. Reset has priority over any in-flight sequence or simultaneous in_valid.
- FSM states: IDLE, EXT, BRK, EXT_BRK. Bytes are consumed only on in_valid.
- IDLE transitions:
  - E0 -> EXT.
  - F0 -> BRK.
  - 00, FF, E1 -> proto_err set; stay in IDLE; no event.
  - Any other byte -> make event {0,0,byte}.
- EXT transitions:
  - F0 -> EXT_BRK.
  - E0, 00, FF -> proto_err set; go to IDLE.
  - Any other byte -> make event {0,1,byte}; go to IDLE.
- BRK:
  - E0, F0, 00, FF -> proto_err set; go to IDLE.
  - Any other byte -> break event {1,0,byte}; go to IDLE.
- EXT_BRK: same as BRK, but the break event is {1,1,byte}.
- Repeat filter: a make whose {ext,code} equals held_code while held_valid=1 is suppressed when REPEAT_FILTER=1. A suppressed make produces no FIFO push, no press_cnt change and no caps toggle.
- Accepted make:
  - press_cnt +1, wrapping modulo 2^CNT_W.
  - held_code <= {ext,code}; held_valid <= 1.
  - Non-extended 58 toggles caps_lock.
- Break:
  - held_valid clears only if {ext,code} equals held_code.
  - Modifier bits clear on their own break regardless of held_code.
  - A break is always pushed, even with no matching make.
- Modifier flags: four internal bits (lshift, rshift, lctrl, rctrl). Each sets on its make, including suppressed repeats, and clears on its break. shift = lshift|rshift; ctrl = lctrl|rctrl.
- Latency: the event is written into the FIFO at the clk edge that samples the final byte. If the FIFO was empty, evt_valid rises and evt_data is valid on the following cycle. All status outputs update at that same edge.
- FIFO: first-word-fall-through. evt_data shows the head whenever evt_valid=1 and holds stable until popped.
  - Pop only when evt_valid && evt_ready; evt_ready while empty is ignored.
  - Push while full with no pop in the same cycle: event dropped, overflow <= 1, FIFO contents unchanged.
  - Push and pop in the same cycle while full: both occur and count stays FIFO_DEPTH.
  - Push and pop in the same cycle otherwise: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags: overflow and proto_err clear only on reset.

Test Plan:
- Make/break: bytes 1C, F0, 1C, ready=1 -> events 01C then 21C; press_cnt=1; held_valid 1 then 0.
- Extended key with typematic repeat, REPEAT_FILTER=1: E0 75, E0 75, E0 75, E0 F0 75 -> only 11C... corrected: only 175 then 375; press_cnt=1; held_code=175 while held. With REPEAT_FILTER=0 -> three 175 events then 375; press_cnt=3.
- Modifiers: 12, 59, F0 12 -> shift stays 1; then F0 59 -> shift=0. E0 14 -> ctrl=1. 58, F0 58, 58 -> caps_lock 1, 1, 0.
- FIFO full, FIFO_DEPTH=4, ready=0: six makes 15,1D,24,2D,2C,35 -> fifo_count=4, overflow=1. Drain yields 015, 01D, 024, 02D. Simultaneous push+pop at full keeps count=4.
- Protocol errors: E0 E0 -> proto_err=1, FSM in IDLE; the next byte 1C yields 01C. F0 F0 -> proto_err=1, no event.
- Reset mid-sequence: E0 then rst=0 for one edge, then 1C -> all outputs 0 after reset; event 01C (not extended); press_cnt=1.
